regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file with NREAD synchronous read ports, one write port and
//  an integrated per-register scoreboard (pending-write busy bits). Sits between decode
//  (read/issue) and write-back in the pipelined datapath. Replaces the fixed 64x32
//  dual-read file: configurable width/depth/ports, hardwired x0, write-first bypass, reset.
// PARAMETERS
//  XLEN      64  data width of each register
//  NREGS     32  number of architectural registers (>=2)
//  NREAD     2   number of read ports (>=1)
//  ZERO_REG  1   1: register 0 hardwired to zero, never busy; 0: register 0 is ordinary
//  (localparam AW = $clog2(NREGS))
// PORTS
//  clock     in   1            single clock, all state updates on rising edge
//  reset     in   1            synchronous, active-high
//  rd_addr   in   NREAD*AW     read addresses, port i at [i*AW +: AW]
//  rd_en     in   NREAD        per-port read enable
//  rd_data   out  NREAD*XLEN   registered read data, port i at [i*XLEN +: XLEN]
//  rd_busy   out  NREAD        registered busy flag of the register read on port i
//  regWrite  in   1            write enable (write-back)
//  wr        in   AW           write address
//  wdata     in   XLEN         write data
//  sb_set    in   1            issue: mark sb_addr as having a pending write
//  sb_addr   in   AW           register to mark busy
//  busy_vec  out  NREGS        current scoreboard, bit r = register r pending
// BEHAVIOUR
//  - Reset (reset=1 at rising edge): all registers, rd_data, rd_busy, busy_vec <= 0.
//    Reset dominates regWrite/sb_set/rd_en in the same cycle.
//  - Write: regWrite=1 -> regs[wr] <= wdata at the edge. Clears busy[wr] (see below).
//  - Read: latency 1. rd_en[i]=1 at edge N -> rd_data[i], rd_busy[i] valid after edge N.
//    rd_en[i]=0 -> rd_data[i], rd_busy[i] hold their previous values.
//  - Bypass (write-first): if regWrite=1 and wr==rd_addr[i] in the same cycle, rd_data[i]
//    <= wdata, not the old contents. Applies independently to every port.
//  - Scoreboard next value: busy_n = busy; if regWrite clear busy_n[wr]; then if sb_set set
//    busy_n[sb_addr]. Same address both: set wins (new producer issued). busy <= busy_n.
//  - rd_busy[i] <= busy_n[rd_addr[i]] (consistent with the bypassed data).
//  - busy_vec is the registered busy state (updates one cycle after sb_set/regWrite).
//  - ZERO_REG=1: reads of reg 0 return 0 (also when bypass would apply), writes to reg 0
//    dropped, sb_set to reg 0 ignored, busy[0] stays 0.
//  - Addresses >= NREGS (non power-of-two NREGS): read returns 0 with rd_busy=0; write and
//    sb_set ignored.
//  - Multiple ports may read the same address in the same cycle; all get identical results.
//  - Reset asserted mid-operation: busy bits and outputs cleared on that edge; pending
//    write-backs after reset are accepted as ordinary writes (clear already-clear bits).
// TESTING
//  1 reset=1 with regWrite=1,wr=5,wdata=0xAA, sb_set=1 -> regs/rd_data/busy_vec all 0 after edge.
//  2 write wr=3,wdata=64'h1234; next cycle rd_addr0=3,rd_en0=1 -> rd_data0=64'h1234 one edge later.
//  3 same cycle regWrite wr=7,wdata=0x55 and rd_addr1=7,rd_en1=1 -> rd_data1=0x55 (bypass).
//  4 ZERO_REG=1: write wr=0,wdata=0xFF, sb_set sb_addr=0; read reg 0 -> rd_data=0, rd_busy=0, busy_vec[0]=0.
//  5 sb_set sb_addr=9 -> busy_vec[9]=1; read 9 -> rd_busy=1; regWrite wr=9 -> busy_vec[9]=0.
//  6 regWrite wr=4 and sb_set sb_addr=4 same cycle -> busy_vec[4]=1; NREAD=4 all ports read 4 -> equal data.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with NREAD registered read ports, one write port, write-first
// bypass and a per-register pending-write scoreboard.
module regfile_sb #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  input  logic [NREAD-1:0]      rd_en,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  regWrite,
  input  logic [AW-1:0]         wr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  output logic [NREGS-1:0]      busy_vec
);

  localparam logic [AW:0] LIM = (AW+1)'(NREGS);

  logic [XLEN-1:0]       r_regs [NREGS];
  logic [NREGS-1:0]      r_busy;
  logic [NREAD*XLEN-1:0] r_rd_data;
  logic [NREAD-1:0]      r_rd_busy;

  logic [NREGS-1:0]      w_busy_n;
  logic [XLEN-1:0]       w_rd_d [NREAD];
  logic [NREAD-1:0]      w_rd_b;
  logic                  w_we;
  logic                  w_set;

  function automatic logic f_valid(input logic [AW-1:0] a);
    return {1'b0, a} < LIM;
  endfunction

  // Valid and, when x0 is hardwired, not register 0.
  function automatic logic f_wok(input logic [AW-1:0] a);
    return f_valid(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_we  = regWrite && f_wok(wr);
  assign w_set = sb_set && f_wok(sb_addr);

  // Set after clear: a newly issued producer outranks the retiring one.
  always_comb begin
    w_busy_n = r_busy;
    if (w_we)
      w_busy_n[wr] = 1'b0;
    if (w_set)
      w_busy_n[sb_addr] = 1'b1;
  end

  always_comb begin
    logic [AW-1:0] w_a;
    for (int i = 0; i < NREAD; i++) begin
      w_a       = rd_addr[i*AW +: AW];
      w_rd_d[i] = '0;
      w_rd_b[i] = 1'b0;
      if (f_valid(w_a)) begin
        if ((ZERO_REG != 0) && (w_a == '0))
          w_rd_d[i] = '0;
        else if (w_we && (wr == w_a))
          w_rd_d[i] = wdata;
        else
          w_rd_d[i] = r_regs[w_a];
        w_rd_b[i] = w_busy_n[w_a];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        r_regs[r] <= '0;
      r_busy    <= '0;
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      if (w_we)
        r_regs[wr] <= wdata;
      r_busy <= w_busy_n;
      for (int i = 0; i < NREAD; i++) begin
        if (rd_en[i]) begin
          r_rd_data[i*XLEN +: XLEN] <= w_rd_d[i];
          r_rd_busy[i]              <= w_rd_b[i];
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_busy  = r_rd_busy;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Vector-table bench for regfile_sb (4 read ports, 24 registers, x0 hardwired);
// expected results queued at drive time and compared after the edge.
module tb_regfile_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 24;
  localparam int NREAD = 4;
  localparam int AW    = 5;

  logic                  clock;
  logic                  reset;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD-1:0]      rd_en;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  regWrite;
  logic [AW-1:0]         wr;
  logic [XLEN-1:0]       wdata;
  logic                  sb_set;
  logic [AW-1:0]         sb_addr;
  logic [NREGS-1:0]      busy_vec;

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_busy(rd_busy),
    .regWrite(regWrite), .wr(wr), .wdata(wdata),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .busy_vec(busy_vec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ports 0 and 3 read ra0, ports 1 and 2 read ra1.
  typedef struct {
    logic            rst;
    logic            we;
    logic [AW-1:0]   wr;
    logic [XLEN-1:0] wd;
    logic            set;
    logic [AW-1:0]   sa;
    logic [3:0]      en;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] d0;
    logic            b0;
    logic [XLEN-1:0] d1;
    logic            b1;
    logic [NREGS-1:0] bv;
  } vec_t;

  vec_t tbl [16];
  vec_t q [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare();
    vec_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL queue: no expected entry");
      return;
    end
    e = q.pop_front();
    chk("rd_data0", rd_data[0*XLEN +: XLEN], e.d0);
    chk("rd_data1", rd_data[1*XLEN +: XLEN], e.d1);
    chk("rd_data2", rd_data[2*XLEN +: XLEN], e.d1);
    chk("rd_data3", rd_data[3*XLEN +: XLEN], e.d0);
    chk("rd_busy0", 64'(rd_busy[0]), 64'(e.b0));
    chk("rd_busy1", 64'(rd_busy[1]), 64'(e.b1));
    chk("rd_busy2", 64'(rd_busy[2]), 64'(e.b1));
    chk("rd_busy3", 64'(rd_busy[3]), 64'(e.b0));
    chk("busy_vec", 64'(busy_vec), 64'(e.bv));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    reset    = v.rst;
    regWrite = v.we;
    wr       = v.wr;
    wdata    = v.wd;
    sb_set   = v.set;
    sb_addr  = v.sa;
    rd_en    = v.en;
    rd_addr  = {v.ra0, v.ra1, v.ra1, v.ra0};
    q.push_back(v);
    @(posedge clock);
    #1;
    compare();
  endtask

  initial begin
    reset = 1'b1; regWrite = 1'b0; wr = '0; wdata = '0;
    sb_set = 1'b0; sb_addr = '0; rd_en = '0; rd_addr = '0;

    //          rst we wr  wd         set sa en       ra0 ra1 d0         b0 d1         b1 bv
    tbl[0]  = '{1, 1, 5,  64'hAA,    1, 5,  4'hF,    5,  5,  64'h0,     0, 64'h0,     0, 24'h0};
    tbl[1]  = '{0, 1, 3,  64'h1234,  0, 0,  4'h0,    3,  3,  64'h0,     0, 64'h0,     0, 24'h0};
    tbl[2]  = '{0, 0, 0,  64'h0,     0, 0,  4'hF,    3,  5,  64'h1234,  0, 64'h0,     0, 24'h0};
    tbl[3]  = '{0, 1, 7,  64'h55,    0, 0,  4'hF,    3,  7,  64'h1234,  0, 64'h55,    0, 24'h0};
    tbl[4]  = '{0, 1, 0,  64'hFF,    1, 0,  4'hF,    0,  0,  64'h0,     0, 64'h0,     0, 24'h0};
    tbl[5]  = '{0, 0, 0,  64'h0,     1, 9,  4'hF,    9,  7,  64'h0,     1, 64'h55,    0, 24'h000200};
    tbl[6]  = '{0, 0, 0,  64'h0,     0, 0,  4'hF,    9,  3,  64'h0,     1, 64'h1234,  0, 24'h000200};
    tbl[7]  = '{0, 1, 9,  64'h99,    0, 0,  4'hF,    9,  9,  64'h99,    0, 64'h99,    0, 24'h0};
    tbl[8]  = '{0, 1, 4,  64'h44,    1, 4,  4'hF,    4,  4,  64'h44,    1, 64'h44,    1, 24'h000010};
    tbl[9]  = '{0, 0, 0,  64'h0,     0, 0,  4'h0,    3,  7,  64'h44,    1, 64'h44,    1, 24'h000010};
    tbl[10] = '{0, 0, 0,  64'h0,     0, 0,  4'b1001, 3,  7,  64'h1234,  0, 64'h44,    1, 24'h000010};
    tbl[11] = '{0, 1, 30, 64'hDEAD,  1, 30, 4'hF,    30, 4,  64'h0,     0, 64'h44,    1, 24'h000010};
    tbl[12] = '{0, 1, 23, 64'h2323,  1, 23, 4'b0110, 1,  23, 64'h0,     0, 64'h2323,  1, 24'h800010};
    tbl[13] = '{0, 1, 4,  64'h4444,  0, 0,  4'hF,    4,  23, 64'h4444,  0, 64'h2323,  1, 24'h800000};
    tbl[14] = '{1, 1, 6,  64'h66,    1, 6,  4'hF,    23, 3,  64'h0,     0, 64'h0,     0, 24'h0};
    tbl[15] = '{0, 1, 23, 64'h1,     0, 0,  4'hF,    23, 3,  64'h1,     0, 64'h0,     0, 24'h0};

    for (int i = 0; i < 16; i++)
      apply(tbl[i]);

    // Busy bit survives idle cycles; retire 12 while issuing 13.
    apply('{0, 0, 0,  64'h0,   1, 12, 4'hF, 12, 13, 64'h0,   1, 64'h0,   0, 24'h001000});
    apply('{0, 0, 0,  64'h0,   0, 0,  4'h0, 12, 13, 64'h0,   1, 64'h0,   0, 24'h001000});
    apply('{0, 0, 0,  64'h0,   0, 0,  4'h0, 12, 13, 64'h0,   1, 64'h0,   0, 24'h001000});
    apply('{0, 1, 12, 64'hC0DE, 1, 13, 4'hF, 12, 13, 64'hC0DE, 0, 64'h0,   1, 24'h002000});
    apply('{0, 1, 13, 64'h1313, 0, 0,  4'hF, 12, 13, 64'hC0DE, 0, 64'h1313, 0, 24'h0});

    // Reset while a write and a read are both in flight.
    apply('{1, 1, 12, 64'h7,   1, 12, 4'hF, 12, 13, 64'h0,   0, 64'h0,   0, 24'h0});
    apply('{0, 0, 0,  64'h0,   0, 0,  4'hF, 12, 13, 64'h0,   0, 64'h0,   0, 24'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
